// File: rtl/sfr_pkg.sv
// sfr_pkg: shared state type, register map and status bit positions for the scroll frame reader
package sfr_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, DATA} sfr_state_t;
  localparam logic [2:0] REG_BG_W   = 3'd0;
  localparam logic [2:0] REG_BG_H   = 3'd1;
  localparam logic [2:0] REG_OFF_X  = 3'd2;
  localparam logic [2:0] REG_OFF_Y  = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam int ST_BUSY    = 0;
  localparam int ST_CFG_ERR = 1;
  localparam int ST_FC_LSB  = 16;
endpackage

// File: rtl/sfr_regs.sv
// sfr_regs: control/status slave holding background size, scroll offsets and enable
module sfr_regs
  import sfr_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [2:0]  avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        busy,
  input  logic        cfg_err,
  input  logic [15:0] frame_count,
  output logic [15:0] bg_w,
  output logic [15:0] bg_h,
  output logic [15:0] off_x,
  output logic [15:0] off_y,
  output logic        enable
);
  logic [31:0] status;
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:16];
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_CFG_ERR] = cfg_err;
    status[ST_FC_LSB +: 16] = frame_count;
  end
  assign avs_readdata = !avs_read                 ? 32'd0 :
                        avs_address == REG_BG_W   ? {16'd0, bg_w} :
                        avs_address == REG_BG_H   ? {16'd0, bg_h} :
                        avs_address == REG_OFF_X  ? {16'd0, off_x} :
                        avs_address == REG_OFF_Y  ? {16'd0, off_y} :
                        avs_address == REG_CTRL   ? {31'd0, enable} :
                        avs_address == REG_STATUS ? status : 32'd0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bg_w   <= '0;
      bg_h   <= '0;
      off_x  <= '0;
      off_y  <= '0;
      enable <= 1'b0;
    end else if (avs_write) begin
      if (avs_address == REG_BG_W) bg_w <= avs_writedata[15:0];
      if (avs_address == REG_BG_H) bg_h <= avs_writedata[15:0];
      if (avs_address == REG_OFF_X) off_x <= avs_writedata[15:0];
      if (avs_address == REG_OFF_Y) off_y <= avs_writedata[15:0];
      if (avs_address == REG_CTRL) enable <= avs_writedata[0];
    end
  end
endmodule

// File: rtl/scroll_frame_reader.sv
// scroll_frame_reader: burst-reads a scrolled IMG_W x IMG_H window of a larger background into a pixel FIFO
module scroll_frame_reader
  import sfr_pkg::*;
#(
  parameter int          IMG_W       = 640,
  parameter int          IMG_H       = 480,
  parameter int          BURST_LEN   = 8,
  parameter int          FIFO_DEPTH  = 512,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          INIT_CYCLES = 33550
)(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          avm_waitrequest,
  input  logic                          avm_readdatavalid,
  input  logic [31:0]                   avm_readdata,
  output logic                          avm_read,
  output logic [29:0]                   avm_address,
  output logic [4:0]                    avm_burstcount,
  output logic [3:0]                    avm_byteenable,
  input  logic                          avs_write,
  input  logic                          avs_read,
  input  logic [2:0]                    avs_address,
  input  logic [31:0]                   avs_writedata,
  output logic [31:0]                   avs_readdata,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_used,
  output logic                          fifo_wr_en,
  output logic [31:0]                   fifo_wr_data,
  input  logic                          pll_locked,
  output logic                          frame_start
);
  sfr_state_t state, state_n;
  logic [15:0] bg_w, bg_h, off_x, off_y, x, y, frame_count, offx_s, offy_s, ox, oy, lim_x, lim_y;
  logic enable, busy, cfg_ok, cfg_err, init_done, space_ok, first, accept, last, unused_addr;
  logic [31:0] init_cnt, addr_n;
  logic [29:0] addr_q;
  logic [4:0] beat;
  sfr_regs u_regs (
    .clk(clk), .reset_n(reset_n), .avs_write(avs_write), .avs_read(avs_read),
    .avs_address(avs_address), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .busy(busy), .cfg_err(cfg_err), .frame_count(frame_count),
    .bg_w(bg_w), .bg_h(bg_h), .off_x(off_x), .off_y(off_y), .enable(enable)
  );
  assign init_done = init_cnt == 32'(INIT_CYCLES);
  assign cfg_ok = bg_w >= 16'(IMG_W) && bg_h >= 16'(IMG_H);
  assign cfg_err = enable && !cfg_ok;
  assign busy = state != IDLE;
  assign space_ok = 32'(fifo_used) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH);
  assign first = x == 16'd0 && y == 16'd0;
  assign lim_x = bg_w - 16'(IMG_W);
  assign lim_y = bg_h - 16'(IMG_H);
  assign ox = !first ? offx_s : off_x < lim_x ? off_x : lim_x;
  assign oy = !first ? offy_s : off_y < lim_y ? off_y : lim_y;
  assign addr_n = BASE_ADDR + (((32'(oy) + 32'(y)) * 32'(bg_w) + 32'(ox) + 32'(x)) << 2);
  assign unused_addr = ^addr_n[31:30];
  assign accept = state == REQ && !avm_waitrequest;
  assign fifo_wr_en = state == DATA && avm_readdatavalid;
  assign fifo_wr_data = avm_readdata;
  assign last = fifo_wr_en && beat == 5'(BURST_LEN - 1);
  assign avm_read = state == REQ;
  assign avm_address = addr_q;
  assign avm_burstcount = 5'(BURST_LEN);
  assign avm_byteenable = 4'hF;
  assign frame_start = accept && first;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = init_done && enable && cfg_ok ? WAIT_SPACE : IDLE;
      WAIT_SPACE: state_n = !enable ? IDLE : space_ok ? REQ : WAIT_SPACE;
      REQ:        state_n = accept ? DATA : REQ;
      DATA:       state_n = !last ? DATA : enable ? WAIT_SPACE : IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      init_cnt    <= '0;
      offx_s      <= '0;
      offy_s      <= '0;
      addr_q      <= '0;
      beat        <= '0;
    end else begin
      state <= state_n;
      if (pll_locked && !init_done) init_cnt <= init_cnt + 32'd1;
      if (state == WAIT_SPACE && state_n == REQ) begin
        addr_q <= addr_n[29:0];
        offx_s <= ox;
        offy_s <= oy;
      end
      if (accept) beat <= '0;
      else if (fifo_wr_en) beat <= beat + 5'd1;
      if (state != IDLE && state_n == IDLE) begin
        x <= '0;
        y <= '0;
      end else if (last) begin
        if (x == 16'(IMG_W - BURST_LEN)) begin
          x <= '0;
          y <= y == 16'(IMG_H - 1) ? 16'd0 : y + 16'd1;
          if (y == 16'(IMG_H - 1)) frame_count <= frame_count + 16'd1;
        end else begin
          x <= x + 16'(BURST_LEN);
        end
      end
    end
  end
endmodule

// File: tb/tb_scroll_frame_reader.sv
// tb_scroll_frame_reader: randomized scoreboard bench against a frame-order address model
module tb_scroll_frame_reader;
  import sfr_pkg::*;
  localparam int IMG_W = 32, IMG_H = 4, BL = 8, FD = 64, INIT = 20;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int BPL = IMG_W / BL, NB = BPL * IMG_H;
  logic clk, reset_n, avm_waitrequest, avm_readdatavalid, avm_read, avs_write, avs_read;
  logic fifo_wr_en, pll_locked, frame_start;
  logic [31:0] avm_readdata, avs_writedata, avs_readdata, fifo_wr_data;
  logic [29:0] avm_address;
  logic [4:0] avm_burstcount;
  logic [3:0] avm_byteenable;
  logic [2:0] avs_address;
  logic [6:0] fifo_used;
  typedef struct {logic [29:0] addr; bit first;} exp_t;
  exp_t exp_q[$];
  logic [31:0] data_q[$];
  int total = 0, bad = 0, acc_cnt = 0, wr_cnt = 0, req_run = 0, last_req_len = 0, pending = 0, force_wait = -1;
  bit drop = 0, stray = 0, fifo_rand = 1;
  scroll_frame_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BURST_LEN(BL), .FIFO_DEPTH(FD), .BASE_ADDR(BASE), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .avm_read(avm_read), .avm_address(avm_address),
    .avm_burstcount(avm_burstcount), .avm_byteenable(avm_byteenable), .avs_write(avs_write),
    .avs_read(avs_read), .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .fifo_used(fifo_used), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .pll_locked(pll_locked), .frame_start(frame_start)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic void push_frame(input int ox, input int oy, input int bgw, input int bgh);
    int cx, cy;
    cx = ox < bgw - IMG_W ? ox : bgw - IMG_W;
    cy = oy < bgh - IMG_H ? oy : bgh - IMG_H;
    for (int k = 0; k < NB; k++) begin
      int px, py;
      logic [31:0] a;
      px = (k % BPL) * BL;
      py = k / BPL;
      a = BASE + 32'(4 * ((cy + py) * bgw + cx + px));
      exp_q.push_back('{a[29:0], k == 0});
    end
  endfunction
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1; avs_address = a;
    #1 d = avs_readdata;
    avs_read = 0;
  endtask
  task automatic wait_status(input string name, input logic [31:0] mask, input logic [31:0] val, input int max);
    logic [31:0] d;
    d = 0;
    for (int i = 0; i < max; i++) begin
      rd(REG_STATUS, d);
      if ((d & mask) == val) break;
    end
    chk(name, d & mask, val);
  endtask
  task automatic wait_acc(input string name, input int target, input int max);
    for (int i = 0; i < max && acc_cnt < target; i++) @(negedge clk);
    chk(name, 32'(acc_cnt >= target), 1);
  endtask
  task automatic wait_wr(input string name, input int target, input int max);
    for (int i = 0; i < max && wr_cnt < target; i++) @(negedge clk);
    chk(name, 32'(wr_cnt >= target), 1);
  endtask
  // Avalon slave memory model with random waitrequest and readdatavalid gaps
  initial begin
    int wl;
    wl = -1;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0; fifo_used = 0;
    forever begin
      @(negedge clk);
      if (fifo_rand) fifo_used = 7'($urandom_range(0, FD - 1));
      if (pending > 0 && $urandom_range(0, 3) != 0) begin
        avm_readdatavalid = 1;
        avm_readdata = $urandom;
        if (!drop) data_q.push_back(avm_readdata);
        pending--;
      end else begin
        avm_readdatavalid = stray;
        avm_readdata = $urandom;
      end
      if (avm_read && pending == 0) begin
        if (wl < 0) wl = force_wait >= 0 ? force_wait : int'($urandom_range(0, 2));
        if (wl > 0) begin
          avm_waitrequest = 1;
          wl--;
        end else begin
          avm_waitrequest = 0;
          pending = BL;
          wl = -1;
        end
      end else avm_waitrequest = 1'($urandom_range(0, 1));
    end
  end
  // monitor: compares requests and FIFO writes against the scoreboard queues
  initial forever begin
    @(negedge clk);
    #2;
    if (avm_read) begin
      req_run++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read: got addr %0h want no read", avm_address);
      end else begin
        chk("addr", 32'(avm_address), 32'(exp_q[0].addr));
        chk("burstcount", 32'(avm_burstcount), BL);
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        if (!avm_waitrequest) begin
          chk("frame_start", 32'(frame_start), 32'(exp_q[0].first));
          void'(exp_q.pop_front());
          acc_cnt++;
          last_req_len = req_run;
          req_run = 0;
        end
      end
    end else if (frame_start) begin
      total++; bad++;
      $display("FAIL spurious_frame_start: got 1 want 0");
    end
    if (fifo_wr_en) begin
      if (data_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got data %0h want no write", fifo_wr_data);
      end else chk("wr_data", fifo_wr_data, data_q.pop_front());
      wr_cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, want test end");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] d;
    int a0, w0, w2, n;
    reset_n = 0; pll_locked = 0; avs_write = 0; avs_read = 0; avs_address = 0; avs_writedata = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_avm_read", 32'(avm_read), 0);
    chk("rst_avm_address", 32'(avm_address), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_fifo_wr_en", 32'(fifo_wr_en), 0);
    reset_n = 1;
    for (int r = 0; r < 6; r++) begin
      rd(3'(r), d);
      chk("rst_reg", d, 0);
    end
    wr(REG_BG_W, 64);
    wr(REG_BG_H, 8);
    wr(3'd7, 32'h55);
    rd(3'd7, d); chk("undef_reg", d, 0);
    rd(REG_BG_W, d); chk("bg_w_rb", d, 64);
    push_frame(0, 0, 64, 8); push_frame(0, 0, 64, 8); push_frame(0, 0, 64, 8);
    wr(REG_CTRL, 1);
    rd(REG_CTRL, d); chk("ctrl_rb", d, 1);
    repeat (30) @(negedge clk);
    rd(REG_STATUS, d); chk("no_pll_idle", d, 0);
    pll_locked = 1;
    repeat (INIT - 5) @(negedge clk);
    rd(REG_STATUS, d); chk("init_idle", d, 0);
    wait_status("busy_after_init", 1, 1, 20);
    wait_status("frames_2", 32'hFFFF0000, 32'h00020000, 3000);
    wr(REG_CTRL, 0);
    wait_status("idle_a", 1, 0, 100);
    chk("beats_a", wr_cnt, acc_cnt * BL);
    exp_q.delete();
    wr(REG_OFF_X, 500);
    wr(REG_OFF_Y, 200);
    push_frame(500, 200, 64, 8); push_frame(5, 200, 64, 8); push_frame(5, 200, 64, 8);
    a0 = acc_cnt;
    wr(REG_CTRL, 1);
    wait_acc("mid_frame", a0 + 3, 200);
    wr(REG_OFF_X, 5);
    wait_status("frames_4", 32'hFFFF0000, 32'h00040000, 3000);
    wr(REG_CTRL, 0);
    wait_status("idle_b", 1, 0, 100);
    chk("beats_b", wr_cnt, acc_cnt * BL);
    exp_q.delete();
    fifo_rand = 0;
    fifo_used = 57;
    push_frame(5, 200, 64, 8); push_frame(5, 200, 64, 8);
    wr(REG_CTRL, 1);
    wait_status("busy_c", 1, 1, 10);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      #2 if (avm_read) n++;
    end
    chk("space_hold", n, 0);
    @(negedge clk);
    force_wait = 3;
    fifo_used = 56;
    @(negedge clk);
    #2 chk("space_go", 32'(avm_read), 1);
    a0 = acc_cnt;
    wait_acc("accept_c", a0 + 1, 20);
    chk("wait_len", last_req_len, 4);
    force_wait = -1;
    w0 = wr_cnt;
    wait_wr("three_beats", w0 + 3, 50);
    wr(REG_CTRL, 0);
    wait_status("idle_d", 1, 0, 100);
    chk("beats_d", wr_cnt - w0, BL);
    exp_q.delete();
    fifo_rand = 1;
    push_frame(5, 200, 64, 8);
    a0 = acc_cnt;
    wr(REG_CTRL, 1);
    wait_acc("restart", a0 + 2, 200);
    wait_wr("pre_reset", wr_cnt + 2, 100);
    @(negedge clk);
    #1 drop = 1; reset_n = 0;
    @(negedge clk);
    #1 reset_n = 1;
    exp_q.delete();
    w2 = wr_cnt;
    chk("rst2_avm_read", 32'(avm_read), 0);
    chk("rst2_avm_address", 32'(avm_address), 0);
    rd(REG_STATUS, d); chk("rst2_status", d, 0);
    rd(REG_BG_W, d); chk("rst2_bg_w", d, 0);
    repeat (30) @(negedge clk);
    chk("late_beats", wr_cnt, w2);
    for (int i = 0; i < 100 && pending > 0; i++) @(negedge clk);
    drop = 0;
    stray = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      #2 if (fifo_wr_en) n++;
    end
    stray = 0;
    chk("stray_rdv", n, 0);
    wr(REG_BG_W, 16);
    wr(REG_BG_H, 8);
    wr(REG_CTRL, 1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      #2 if (avm_read) n++;
    end
    chk("cfg_no_read", n, 0);
    rd(REG_STATUS, d); chk("cfg_err_status", d, 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
